tx_pulser_ch: RTL and testbench
===============================

Name: tx_pulser_ch

Overview:
- Per-channel transmit beamformer. It is the transmit-side counterpart of the dbf receive channel.
- On a transmit trigger it reads the channel's focal transmit delay from a write-programmable delay LUT and waits that many clocks.
- It then emits a bipolar burst on pulse_p/pulse_n, holds a damping/clamp interval, and signals done.
- tx_en frames the whole event. It feeds the receive channel's tx_en, which blanks receive sampling.

Parameters:
- ADDR_WD, 7, LUT address width; LUT depth = 2^ADDR_WD scan lines.
- DLY_WD, 12, transmit delay width in clocks.
- HP_WD, 6, half-period width in clocks.
- CYC_WD, 4, burst cycle-count width.
- DAMP_CYC, 4, damping interval length in clocks (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- lut_addr  in  ADDR_WD  delay LUT write address.
- lut_din  in  DLY_WD  delay LUT write data.
- lut_we  in  1  LUT write enable.
- line_sel  in  ADDR_WD  scan line used as LUT read address; sampled on an accepted tx_start.
- half_period  in  HP_WD  clocks per half-cycle; sampled on an accepted tx_start.
- num_cycles  in  CYC_WD  burst cycles; sampled on an accepted tx_start.
- tx_start  in  1  single-cycle trigger.
- abort  in  1  terminate the event immediately.
- tx_en  out  1  high while an event is in progress (LOAD through DONE).
- pulse_p  out  1  positive pulser drive.
- pulse_n  out  1  negative pulser drive.
- damp  out  1  clamp switch enable.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset: synchronous, active-high. On reset, FSM goes to IDLE and all outputs are 0. LUT contents are not cleared.
- All outputs are registered.
- Reset mid-burst: outputs are 0 on the following cycle.
- LUT:
  - 2^ADDR_WD x DLY_WD RAM; a write occurs on a clk edge when lut_we=1.
  - Writes are accepted in every state.
  - Read is synchronous (one cycle) and read-first: a same-address write in the LOAD cycle does not affect the current event.
- FSM states: IDLE, LOAD, DELAY, PULSE, DAMP, DONE.
- IDLE:
  - tx_start=1 at cycle T latches line_sel, half_period and num_cycles, then goes to LOAD at T+1.
  - half_period=0 is treated as 1.
- LOAD:
  - tx_en=1; LUT read issued; goes to DELAY.
  - Delay D = LUT[line_sel].
- DELAY:
  - Lasts exactly D cycles (T+2..T+1+D). D=0 skips DELAY.
  - The first PULSE cycle is T+2+D.
- PULSE:
  - Each cycle is half_period clocks with pulse_p=1, then half_period clocks with pulse_n=1.
  - The burst is num_cycles such cycles, back-to-back.
  - num_cycles=0 skips PULSE and goes straight to DAMP; no pulse is emitted.
- DAMP:
  - damp=1 and pulse_p=pulse_n=0 for DAMP_CYC cycles.
- DONE:
  - done=1 and tx_en=1 for one cycle, then IDLE.
  - tx_en falls in the next cycle; a tx_start in that cycle is accepted.
- tx_start outside IDLE is ignored and has no side effect.
- abort=1 in any non-IDLE state: the next cycle is IDLE with all outputs 0 and done not asserted. abort has priority over any state transition.
- tx_start and abort together in IDLE: abort wins and the start is ignored.
- Invariants:
  - pulse_p and pulse_n are never both 1.
  - pulse_*/damp are never 1 while tx_en=0.
  - DLY_WD, HP_WD and CYC_WD counters never wrap; maximum values run to completion.

Test Plan:
- Nominal burst:
  - Stimulus: LUT[3]=5; tx_start at T with line_sel=3, half_period=2, num_cycles=2, DAMP_CYC=4.
  - Required: tx_en rises at T+1; pulse_p at T+7..8; pulse_n at T+9..10; pulse_p at T+11..12; pulse_n at T+13..14; damp at T+15..18; done at T+19; tx_en low at T+20.
- Zero delay / zero cycles:
  - Stimulus: LUT[0]=0; half_period=1, num_cycles=1.
  - Required: pulse_p at T+2; pulse_n at T+3.
  - Then with num_cycles=0: no pulses, damp at T+2..T+5, done at T+6.
- Abort:
  - Stimulus: abort asserted during the second pulse_p half-cycle.
  - Required: next cycle all outputs 0, done never asserted; a new tx_start two cycles later produces a normal burst.
- Busy/overlap:
  - Stimulus: tx_start repeated during DELAY.
  - Required: ignored; timing identical to the nominal case.
  - Stimulus: tx_start in the cycle after done.
  - Required: accepted.
- LUT read-first:
  - Stimulus: lut_we to address 3 with value 9 in the LOAD cycle of an event using line 3 (old value 5).
  - Required: the current event uses delay 5; the next event uses delay 9.
- Reset mid-PULSE and extremes:
  - Stimulus: rst=1 for one cycle during PULSE.
  - Required: outputs 0 next cycle; LUT retained.
  - Stimulus: LUT=4095, half_period=63, num_cycles=15.
  - Required: first pulse at T+4097; burst length exactly 1890 clocks.

Source files
------------

// File: rtl/tx_pulser_ch.sv
// Per-channel transmit pulser: delay-LUT lookup, bipolar burst, damping clamp and done.
// tx_en frames the whole event and blanks the paired receive channel.
module tx_pulser_ch #(
  parameter int ADDR_WD  = 7,
  parameter int DLY_WD   = 12,
  parameter int HP_WD    = 6,
  parameter int CYC_WD   = 4,
  parameter int DAMP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic               lut_we,
  input  logic [ADDR_WD-1:0] line_sel,
  input  logic [HP_WD-1:0]   half_period,
  input  logic [CYC_WD-1:0]  num_cycles,
  input  logic               tx_start,
  input  logic               abort,
  output logic               tx_en,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               damp,
  output logic               done
);

  localparam int DC_WD = (DAMP_CYC < 2) ? 1 : $clog2(DAMP_CYC);
  localparam logic [DC_WD-1:0] DAMP_LAST = DC_WD'(DAMP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DELAY, S_PULSE, S_DAMP, S_DONE} state_t;

  state_t state, state_nx;

  logic [DLY_WD-1:0] lut_mem [2**ADDR_WD];
  logic [DLY_WD-1:0] dly_rd;
  logic [HP_WD-1:0]  hp_lat;
  logic [CYC_WD-1:0] nc_lat;

  logic [DLY_WD-1:0] dly_cnt, dly_nx;
  logic [HP_WD-1:0]  hp_cnt, hp_nx;
  logic [CYC_WD-1:0] cyc_cnt, cyc_nx;
  logic              ph, ph_nx;
  logic [DC_WD-1:0]  dmp_cnt, dmp_nx;

  logic accept;
  logic enter_burst;
  logic tx_en_d, pulse_p_d, pulse_n_d, damp_d, done_d;

  assign accept = (state == S_IDLE) && tx_start && !abort;

  // LUT read is taken on the accepting edge so LOAD already knows the delay;
  // a write during LOAD lands after this read and only affects later events.
  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[lut_addr] <= lut_din;
    if (accept) begin
      dly_rd <= lut_mem[line_sel];
      hp_lat <= (half_period == '0) ? HP_WD'(1) : half_period;
      nc_lat <= num_cycles;
    end
    dly_cnt <= dly_nx;
    hp_cnt  <= hp_nx;
    cyc_cnt <= cyc_nx;
    ph      <= ph_nx;
    dmp_cnt <= dmp_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_en   <= 1'b0;
      pulse_p <= 1'b0;
      pulse_n <= 1'b0;
      damp    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      tx_en   <= tx_en_d;
      pulse_p <= pulse_p_d;
      pulse_n <= pulse_n_d;
      damp    <= damp_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_nx    = state;
    dly_nx      = dly_cnt;
    hp_nx       = hp_cnt;
    cyc_nx      = cyc_cnt;
    ph_nx       = ph;
    dmp_nx      = dmp_cnt;
    enter_burst = 1'b0;
    case (state)
      S_IDLE:  if (tx_start) state_nx = S_LOAD;
      S_LOAD: begin
        if (dly_rd != '0) begin
          state_nx = S_DELAY;
          dly_nx   = dly_rd - DLY_WD'(1);
        end else begin
          enter_burst = 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_cnt == '0) enter_burst = 1'b1;
        else               dly_nx = dly_cnt - DLY_WD'(1);
      end
      S_PULSE: begin
        if (hp_cnt != '0) begin
          hp_nx = hp_cnt - HP_WD'(1);
        end else if (!ph) begin
          ph_nx = 1'b1;
          hp_nx = hp_lat - HP_WD'(1);
        end else if (cyc_cnt != '0) begin
          ph_nx  = 1'b0;
          hp_nx  = hp_lat - HP_WD'(1);
          cyc_nx = cyc_cnt - CYC_WD'(1);
        end else begin
          state_nx = S_DAMP;
          dmp_nx   = DAMP_LAST;
        end
      end
      S_DAMP: begin
        if (dmp_cnt == '0) state_nx = S_DONE;
        else               dmp_nx = dmp_cnt - DC_WD'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // A zero cycle count bypasses the burst entirely.
    if (enter_burst) begin
      if (nc_lat != '0) begin
        state_nx = S_PULSE;
        hp_nx    = hp_lat - HP_WD'(1);
        ph_nx    = 1'b0;
        cyc_nx   = nc_lat - CYC_WD'(1);
      end else begin
        state_nx = S_DAMP;
        dmp_nx   = DAMP_LAST;
      end
    end
    if (abort) state_nx = S_IDLE;
  end

  // Outputs decode the upcoming state so they register in step with it.
  always_comb begin
    tx_en_d   = (state_nx != S_IDLE);
    pulse_p_d = (state_nx == S_PULSE) && !ph_nx;
    pulse_n_d = (state_nx == S_PULSE) && ph_nx;
    damp_d    = (state_nx == S_DAMP);
    done_d    = (state_nx == S_DONE);
  end

endmodule

// File: tb/tb_tx_pulser_ch.sv
// Scoreboard bench for tx_pulser_ch: stimulus queues the expected output trace,
// a monitor pops and compares whenever any output is active.
module tb_tx_pulser_ch;

  localparam int ADDR_WD  = 7;
  localparam int DLY_WD   = 12;
  localparam int HP_WD    = 6;
  localparam int CYC_WD   = 4;
  localparam int DAMP_CYC = 4;
  localparam int BIG      = 1 << 30;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_WD-1:0] lut_addr = '0;
  logic [DLY_WD-1:0]  lut_din = '0;
  logic               lut_we = 1'b0;
  logic [ADDR_WD-1:0] line_sel = '0;
  logic [HP_WD-1:0]   half_period = '0;
  logic [CYC_WD-1:0]  num_cycles = '0;
  logic               tx_start = 1'b0;
  logic               abort = 1'b0;
  logic               tx_en, pulse_p, pulse_n, damp, done;

  tx_pulser_ch #(
    .ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD), .HP_WD(HP_WD),
    .CYC_WD(CYC_WD), .DAMP_CYC(DAMP_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .lut_addr(lut_addr), .lut_din(lut_din), .lut_we(lut_we),
    .line_sel(line_sel), .half_period(half_period), .num_cycles(num_cycles),
    .tx_start(tx_start), .abort(abort),
    .tx_en(tx_en), .pulse_p(pulse_p), .pulse_n(pulse_n),
    .damp(damp), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Vector order: {tx_en, pulse_p, pulse_n, damp, done}
  function automatic void add(int c, logic [4:0] v, int lim);
    exp_t e;
    if (c <= lim) begin
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void push_event(int t, int d, int hp, int nc, int cut);
    int c;
    int hpe;
    int lim;
    hpe = (hp == 0) ? 1 : hp;
    lim = (cut >= BIG) ? BIG : t + cut;
    c = t + 1;
    add(c, 5'b10000, lim); c++;
    for (int i = 0; i < d; i++) begin add(c, 5'b10000, lim); c++; end
    for (int k = 0; k < nc; k++) begin
      for (int i = 0; i < hpe; i++) begin add(c, 5'b11000, lim); c++; end
      for (int i = 0; i < hpe; i++) begin add(c, 5'b10100, lim); c++; end
    end
    for (int i = 0; i < DAMP_CYC; i++) begin add(c, 5'b10010, lim); c++; end
    add(c, 5'b10001, lim);
  endfunction

  always @(negedge clk) begin
    logic [4:0] obs;
    obs = {tx_en, pulse_p, pulse_n, damp, done};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed cyc=%0d got=00000 want=%b", exp_q[0].cyc, exp_q[0].v);
      void'(exp_q.pop_front());
    end
    if (obs != 5'b0) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected cyc=%0d got=%b want=00000", cyc, obs);
      end else begin
        if (obs != exp_q[0].v) begin
          errors++;
          $display("FAIL trace cyc=%0d got=%b want=%b", cyc, obs, exp_q[0].v);
        end
        void'(exp_q.pop_front());
      end
    end
    if ((pulse_p && pulse_n) || ((pulse_p || pulse_n || damp) && !tx_en)) begin
      errors++;
      $display("FAIL invariant cyc=%0d got=%b want=legal", cyc, obs);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick(1);
  endtask

  task automatic lut_write(int a, int d);
    lut_addr = ADDR_WD'(a);
    lut_din  = DLY_WD'(d);
    lut_we   = 1'b1;
    tick(1);
    lut_we   = 1'b0;
  endtask

  task automatic start(int line, int hp, int nc, int d, int cut, output int t);
    line_sel    = ADDR_WD'(line);
    half_period = HP_WD'(hp);
    num_cycles  = CYC_WD'(nc);
    tx_start    = 1'b1;
    t = cyc;
    push_event(t, d, hp, nc, cut);
    tick(1);
    tx_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++;
    if ({tx_en, pulse_p, pulse_n, damp, done} != 5'b0) begin
      errors++;
      $display("FAIL reset_state got=%b want=00000", {tx_en, pulse_p, pulse_n, damp, done});
    end

    lut_write(3, 5);
    lut_write(0, 0);
    lut_write(10, 7);
    lut_write(127, 4095);

    // Nominal, with a repeated start during DELAY that must be ignored
    start(3, 2, 2, 5, BIG, t);
    wait_until(t + 4);
    line_sel = 0; half_period = 1; num_cycles = 0; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    wait_until(t + 20);
    // Start in the cycle right after done
    start(3, 2, 2, 5, BIG, t);
    wait_until(t + 20);

    // Zero delay, single cycle; then zero cycles; then half_period 0
    start(0, 1, 1, 0, BIG, t);
    wait_until(t + 9);
    start(0, 1, 0, 0, BIG, t);
    wait_until(t + 7);
    start(0, 0, 1, 0, BIG, t);
    wait_until(t + 10);

    // Abort in the second pulse_p half-cycle, restart two cycles later
    start(3, 2, 2, 5, 11, t);
    wait_until(t + 11);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_until(t + 13);
    start(3, 2, 2, 5, BIG, t);
    wait_until(t + 21);

    // Abort together with start in IDLE: nothing happens
    abort = 1'b1; tx_start = 1'b1;
    tick(1);
    abort = 1'b0; tx_start = 1'b0;
    tick(4);

    // Read-first: write LUT[3]=9 during LOAD
    start(3, 2, 1, 5, BIG, t);
    lut_write(3, 9);
    wait_until(t + 16);
    start(3, 2, 1, 9, BIG, t);
    wait_until(t + 21);

    // Reset in PULSE, then LUT retained
    start(10, 3, 2, 7, 10, t);
    wait_until(t + 10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    start(10, 3, 1, 7, BIG, t);
    wait_until(t + 20);

    // Extremes
    start(127, 63, 15, 4095, BIG, t);
    wait_until(t + 5995);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
